// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: accepts a PC, issues a single outstanding memory read,
// and queues the returned word (or a fault) in a 2-entry in-order output FIFO.
// Flush discards everything queued or in flight. A misaligned PC produces a
// fault entry directly, without touching memory.
module instr_fetch_unit #(
    parameter int BITS = 64,
    parameter int ILEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [BITS-1:0] pc_in,
    input  logic            pc_valid,
    output logic            pc_ready,
    input  logic            flush,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [BITS-1:0] mem_req_addr,
    input  logic            mem_rsp_valid,
    input  logic [ILEN-1:0] mem_rsp_data,
    input  logic            mem_rsp_err,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [ILEN-1:0] inst_data,
    output logic [BITS-1:0] inst_pc,
    output logic            inst_fault
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [BITS-1:0] addr_q, addr_d;
    logic            flush_seen_q, flush_seen_d;
    logic [1:0]      count_q, count_d;

    // Entry 0 is always the head; a pop shifts entry 1 down.
    logic [ILEN-1:0] fifo_data_q  [2];
    logic [ILEN-1:0] fifo_data_d  [2];
    logic [BITS-1:0] fifo_pc_q    [2];
    logic [BITS-1:0] fifo_pc_d    [2];
    logic            fifo_fault_q [2];
    logic            fifo_fault_d [2];

    logic            accept;
    logic            misaligned;
    logic            rsp_take;
    logic            push;
    logic            pop;
    logic [1:0]      count_after_pop;
    logic [ILEN-1:0] push_data;
    logic [BITS-1:0] push_pc;
    logic            push_fault;

    // Handshake and push/pop decode. Reset also masks pc_ready so nothing is
    // accepted while reset is held.
    always_comb begin
        pc_ready   = (state_q == IDLE) && (count_q != 2'd2) && !flush && !rst;
        accept     = pc_valid && pc_ready;
        misaligned = (pc_in[1:0] != 2'b00);
        rsp_take   = (state_q == WAIT) && mem_rsp_valid && !flush;
        push       = (accept && misaligned) || rsp_take;
        pop        = (count_q != 2'd0) && inst_ready;
        push_data  = (rsp_take && !mem_rsp_err) ? mem_rsp_data : '0;
        push_pc    = rsp_take ? addr_q : pc_in;
        push_fault = rsp_take ? mem_rsp_err : 1'b1;
    end

    // Request/response sequencing; a flush seen while the request is still
    // waiting for mem_req_ready is latched so the response gets dropped.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        flush_seen_d = flush_seen_q;
        case (state_q)
            IDLE: begin
                if (accept && !misaligned) begin
                    state_d      = REQ;
                    addr_d       = pc_in;
                    flush_seen_d = 1'b0;
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    state_d      = (flush || flush_seen_q) ? DRAIN : WAIT;
                    flush_seen_d = 1'b0;
                end else if (flush) begin
                    flush_seen_d = 1'b1;
                end
            end
            WAIT: begin
                if (mem_rsp_valid) begin
                    state_d = IDLE;
                end else if (flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (mem_rsp_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO next state: pop first, then append behind whatever remains; flush wins.
    always_comb begin
        fifo_data_d     = fifo_data_q;
        fifo_pc_d       = fifo_pc_q;
        fifo_fault_d    = fifo_fault_q;
        count_after_pop = count_q;
        count_d         = count_q;
        if (pop) begin
            fifo_data_d[0]  = fifo_data_q[1];
            fifo_pc_d[0]    = fifo_pc_q[1];
            fifo_fault_d[0] = fifo_fault_q[1];
            count_after_pop = count_q - 2'd1;
        end
        count_d = count_after_pop;
        if (push && (count_after_pop != 2'd2)) begin
            fifo_data_d[count_after_pop[0]]  = push_data;
            fifo_pc_d[count_after_pop[0]]    = push_pc;
            fifo_fault_d[count_after_pop[0]] = push_fault;
            count_d                          = count_after_pop + 2'd1;
        end
        if (flush) begin
            count_d = 2'd0;
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            flush_seen_q <= 1'b0;
            count_q      <= 2'd0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            flush_seen_q <= flush_seen_d;
            count_q      <= count_d;
        end
    end

    // Per-entry FIFO storage.
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
        // Entry payload registers.
        always_ff @(posedge clk) begin
            if (rst) begin
                fifo_data_q[gi]  <= '0;
                fifo_pc_q[gi]    <= '0;
                fifo_fault_q[gi] <= 1'b0;
            end else begin
                fifo_data_q[gi]  <= fifo_data_d[gi];
                fifo_pc_q[gi]    <= fifo_pc_d[gi];
                fifo_fault_q[gi] <= fifo_fault_d[gi];
            end
        end
    end

    // Outputs; the head fields read as zero whenever the FIFO is empty.
    always_comb begin
        mem_req_valid = (state_q == REQ);
        mem_req_addr  = addr_q;
        inst_valid    = (count_q != 2'd0);
        inst_data     = inst_valid ? fifo_data_q[0]  : '0;
        inst_pc       = inst_valid ? fifo_pc_q[0]    : '0;
        inst_fault    = inst_valid ? fifo_fault_q[0] : 1'b0;
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: directed scenarios followed by random
// traffic, all checked every cycle against a transaction-level model
// (a queue of expected entries plus a record of the single pending fetch).
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] pc_in = '0;
    logic        pc_valid = 1'b0;
    logic        pc_ready;
    logic        flush = 1'b0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [63:0] mem_req_addr;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = '0;
    logic        mem_rsp_err = 1'b0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [63:0] inst_pc;
    logic        inst_fault;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [31:0] d;
        logic [63:0] pc;
        logic        f;
    } ent_t;

    ent_t        exp_q[$];
    bit          pend = 1'b0;
    bit          pend_acc = 1'b0;
    bit          pend_kill = 1'b0;
    logic [63:0] pend_pc = '0;

    instr_fetch_unit #(.BITS(64), .ILEN(32)) dut (
        .clk(clk), .rst(rst),
        .pc_in(pc_in), .pc_valid(pc_valid), .pc_ready(pc_ready),
        .flush(flush),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .mem_rsp_err(mem_rsp_err),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_data(inst_data), .inst_pc(inst_pc), .inst_fault(inst_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check outputs against the model, clock, advance the model.
    task automatic step();
        ent_t h;
        logic exp_prdy;
        #1;
        h = (exp_q.size() != 0) ? exp_q[0] : '0;
        chk("inst_valid", inst_valid, exp_q.size() != 0);
        chk("inst_data", inst_data, h.d);
        chk("inst_pc", inst_pc, h.pc);
        chk("inst_fault", inst_fault, h.f);
        chk("mem_req_valid", mem_req_valid, pend && !pend_acc);
        if (pend && !pend_acc) chk("mem_req_addr", mem_req_addr, pend_pc);
        exp_prdy = !rst && !pend && (exp_q.size() < 2) && !flush;
        chk("pc_ready", pc_ready, exp_prdy);
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            pend = 0; pend_acc = 0; pend_kill = 0;
        end else begin
            if (exp_q.size() != 0 && inst_ready) void'(exp_q.pop_front());
            if (flush) begin
                exp_q.delete();
                if (pend) pend_kill = 1;
            end
            if (pend) begin
                if (!pend_acc) begin
                    if (mem_req_ready) pend_acc = 1;
                end else if (mem_rsp_valid) begin
                    if (!pend_kill)
                        exp_q.push_back('{d: (mem_rsp_err ? 32'h0 : mem_rsp_data),
                                          pc: pend_pc, f: mem_rsp_err});
                    pend = 0;
                end
            end else if (pc_valid && exp_prdy) begin
                if (pc_in[1:0] == 2'b00) begin
                    pend = 1; pend_acc = 0; pend_kill = 0; pend_pc = pc_in;
                end else begin
                    exp_q.push_back('{d: 32'h0, pc: pc_in, f: 1'b1});
                end
            end
        end
        #1;
    endtask

    // Accept at cycle 0, handshake at cycle 1, respond at cycle 3.
    task automatic fetch(input logic [63:0] pc, input logic [31:0] data, input logic err);
        pc_in = pc; pc_valid = 1; step();
        pc_valid = 0; mem_req_ready = 1; step();
        mem_req_ready = 0; step();
        mem_rsp_valid = 1; mem_rsp_data = data; mem_rsp_err = err; step();
        mem_rsp_valid = 0; mem_rsp_err = 0;
    endtask

    initial begin
        // Reset state, checked while reset is still held.
        @(posedge clk); @(posedge clk); #1;
        chk("rst_pc_ready", pc_ready, 0);
        chk("rst_mem_req_valid", mem_req_valid, 0);
        chk("rst_mem_req_addr", mem_req_addr, 0);
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_inst_data", inst_data, 0);
        chk("rst_inst_pc", inst_pc, 0);
        chk("rst_inst_fault", inst_fault, 0);
        rst = 0;

        // Basic fetch.
        fetch(64'h100, 32'h00500093, 1'b0);
        chk("basic_valid", inst_valid, 1);
        chk("basic_data", inst_data, 32'h00500093);
        chk("basic_pc", inst_pc, 64'h100);
        chk("basic_fault", inst_fault, 0);
        inst_ready = 1; step(); inst_ready = 0;

        // Misaligned PC: immediate fault, no memory request.
        pc_in = 64'h102; pc_valid = 1; step(); pc_valid = 0;
        chk("mis_req_valid", mem_req_valid, 0);
        chk("mis_valid", inst_valid, 1);
        chk("mis_fault", inst_fault, 1);
        chk("mis_pc", inst_pc, 64'h102);
        chk("mis_data", inst_data, 0);
        inst_ready = 1; step(); inst_ready = 0;

        // Backpressure: two entries fill the FIFO, then drain in order.
        fetch(64'h0, 32'h11111111, 1'b0);
        fetch(64'h4, 32'h22222222, 1'b0);
        #1;
        chk("bp_pc_ready", pc_ready, 0);
        chk("bp_head_pc0", inst_pc, 64'h0);
        inst_ready = 1; step();
        chk("bp_head_pc4", inst_pc, 64'h4);
        chk("bp_head_data4", inst_data, 32'h22222222);
        step(); inst_ready = 0;
        chk("bp_empty", inst_valid, 0);

        // Flush while waiting for the response.
        pc_in = 64'h180; pc_valid = 1; step();
        pc_valid = 0; mem_req_ready = 1; step();
        mem_req_ready = 0; flush = 1; step();
        flush = 0; mem_rsp_valid = 1; mem_rsp_data = 32'hDEADBEEF; step();
        mem_rsp_valid = 0;
        chk("flush_dropped", inst_valid, 0);
        fetch(64'h200, 32'h00000013, 1'b0);
        chk("flush_next_valid", inst_valid, 1);
        chk("flush_next_pc", inst_pc, 64'h200);
        chk("flush_next_data", inst_data, 32'h00000013);
        inst_ready = 1; step(); inst_ready = 0;

        // Access error.
        fetch(64'h300, 32'h12345678, 1'b1);
        chk("err_fault", inst_fault, 1);
        chk("err_data", inst_data, 0);
        chk("err_pc", inst_pc, 64'h300);
        inst_ready = 1; step(); inst_ready = 0;

        // Reset in WAIT, then a stale response.
        pc_in = 64'h400; pc_valid = 1; step();
        pc_valid = 0; mem_req_ready = 1; step();
        mem_req_ready = 0; step();
        rst = 1; step();
        rst = 0; mem_rsp_valid = 1; mem_rsp_data = 32'hCAFEF00D; step();
        mem_rsp_valid = 0; #1;
        chk("rstw_inst_valid", inst_valid, 0);
        chk("rstw_inst_data", inst_data, 0);
        chk("rstw_inst_pc", inst_pc, 0);
        chk("rstw_inst_fault", inst_fault, 0);
        chk("rstw_req_valid", mem_req_valid, 0);
        chk("rstw_pc_ready", pc_ready, 1);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            pc_valid      = ($urandom_range(1, 0) == 1);
            pc_in         = {$urandom, $urandom};
            if ($urandom_range(4, 0) != 0) pc_in[1:0] = 2'b00;
            flush         = ($urandom_range(19, 0) == 0);
            mem_req_ready = ($urandom_range(1, 0) == 1);
            mem_rsp_valid = ($urandom_range(4, 0) < 2);
            mem_rsp_data  = $urandom;
            mem_rsp_err   = ($urandom_range(6, 0) == 0);
            inst_ready    = ($urandom_range(2, 0) != 0);
            rst           = ($urandom_range(99, 0) == 0);
            step();
        end
        rst = 0; pc_valid = 0; flush = 0; mem_rsp_valid = 0; inst_ready = 0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
